// File: rtl/div_seq_ctrl_pkg.sv
// Shared types and constants for the div_seq_ctrl divider sequencer.
package div_seq_ctrl_pkg;

  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = $clog2(ITER);

  localparam logic        DIV_RESULT_READY     = 1'b1;
  localparam logic        DIV_RESULT_NOT_READY = 1'b0;
  localparam logic [31:0] ZERO_WORD            = '0;

  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_seq_ctrl_if.sv
// Request/result bundle between the execute stage and the divider.
interface div_seq_ctrl_if;
  logic        start_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stall_o;

  modport master (
    output start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o, stall_o
  );

  modport slave (
    input  start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o, stall_o
  );
endinterface

// File: rtl/div_seq_ctrl_iter.sv
// One combinational restoring-division step: shift in the next dividend bit, try-subtract.
module div_iter (
  input  logic [31:0] pr_i,
  input  logic        dvd_msb_i,
  input  logic [31:0] dvs_i,
  output logic [31:0] pr_o,
  output logic        q_o
);

  logic [32:0] shifted;
  logic [31:0] rem;

  // Compare on 33 bits so a shifted-out partial-remainder MSB is never lost;
  // when the subtract succeeds the result is below dvs and fits in 32 bits.
  always_comb begin
    shifted = {pr_i, dvd_msb_i};
    q_o     = (shifted >= {1'b0, dvs_i});
    rem     = shifted[31:0] - dvs_i;
    pr_o    = q_o ? rem : shifted[31:0];
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle restoring divider sequencer for DIV/DIVU with pipeline stall and annul.
module div_seq_ctrl
  import div_seq_ctrl_pkg::*;
(
  input logic            clk,
  input logic            rst,
  div_seq_ctrl_if.slave  bus
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      dvd_q, dvd_d;
  logic [31:0]      dvs_q, dvs_d;
  logic [31:0]      pr_q, pr_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             ready_q, ready_d;
  logic [63:0]      result_q, result_d;

  logic [31:0] pr_nxt;
  logic        q_bit;
  logic [31:0] quo_raw;
  logic        op1_neg;
  logic        op2_neg;

  div_iter u_iter (
    .pr_i      (pr_q),
    .dvd_msb_i (dvd_q[31]),
    .dvs_i     (dvs_q),
    .pr_o      (pr_nxt),
    .q_o       (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      pr_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      ready_q   <= DIV_RESULT_NOT_READY;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      pr_q      <= pr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      ready_q   <= ready_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    pr_d      = pr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    ready_d   = ready_q;
    result_d  = result_q;
    quo_raw   = {dvd_q[30:0], q_bit};
    op1_neg   = bus.signed_div_i & bus.opdata1_i[31];
    op2_neg   = bus.signed_div_i & bus.opdata2_i[31];

    unique case (state_q)
      DIV_FREE: begin
        if (bus.start_i && !bus.annul_i) begin
          neg_quo_d = op1_neg ^ op2_neg;
          neg_rem_d = op1_neg;
          dvd_d     = op1_neg ? (ZERO_WORD - bus.opdata1_i) : bus.opdata1_i;
          dvs_d     = op2_neg ? (ZERO_WORD - bus.opdata2_i) : bus.opdata2_i;
          cnt_d     = '0;
          pr_d      = '0;
          state_d   = (bus.opdata2_i == ZERO_WORD) ? DIV_BYZERO : DIV_ON;
        end
      end

      DIV_BYZERO: begin
        result_d = {ZERO_WORD, ZERO_WORD};
        if (bus.annul_i) begin
          state_d = DIV_FREE;
          ready_d = DIV_RESULT_NOT_READY;
        end else begin
          state_d = DIV_END;
          ready_d = DIV_RESULT_READY;
        end
      end

      DIV_ON: begin
        if (bus.annul_i) begin
          state_d  = DIV_FREE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = {ZERO_WORD, ZERO_WORD};
        end else begin
          pr_d  = pr_nxt;
          dvd_d = quo_raw;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(ITER - 1)) begin
            // Sign fixup folds into the final step so END holds the finished result.
            state_d  = DIV_END;
            ready_d  = DIV_RESULT_READY;
            result_d = {neg_rem_q ? (ZERO_WORD - pr_nxt)  : pr_nxt,
                        neg_quo_q ? (ZERO_WORD - quo_raw) : quo_raw};
          end
        end
      end

      DIV_END: begin
        if (bus.annul_i || !bus.start_i) begin
          state_d  = DIV_FREE;
          ready_d  = DIV_RESULT_NOT_READY;
          result_d = {ZERO_WORD, ZERO_WORD};
        end
      end

      default: state_d = DIV_FREE;
    endcase
  end

  assign bus.stall_o  = ((state_q == DIV_FREE) && bus.start_i && !bus.annul_i) ||
                        (state_q == DIV_BYZERO) ||
                        ((state_q == DIV_ON) && !bus.annul_i);
  assign bus.ready_o  = ready_q;
  assign bus.result_o = result_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed self-checking bench for div_seq_ctrl.
module tb_div_seq_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  div_seq_ctrl_if bus ();

  div_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one divide, wait for ready with a cycle budget, optionally hold start, then release.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_res,
                        input int exp_lat, input int hold);
    int   lat;
    logic stall_ok;
    logic [63:0] held;
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    #1;
    chk({tag, "_stall_c0"}, bus.stall_o, 1);
    lat = 0;
    stall_ok = 1'b1;
    while (!bus.ready_o && lat < 40) begin
      tick();
      lat++;
      if (!bus.ready_o && bus.stall_o !== 1'b1) stall_ok = 1'b0;
    end
    chk({tag, "_ready"}, bus.ready_o, 1);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_result"}, bus.result_o, exp_res);
    chk({tag, "_stall_run"}, stall_ok, 1);
    chk({tag, "_stall_end"}, bus.stall_o, 0);
    held = bus.result_o;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_ready"}, bus.ready_o, 1);
      chk({tag, "_hold_result"}, bus.result_o, exp_res);
    end
    if (hold > 0) chk({tag, "_hold_vs_first"}, bus.result_o, held);
    bus.start_i = 1'b0;
    tick();
    chk({tag, "_rel_ready"}, bus.ready_o, 0);
    chk({tag, "_rel_result"}, bus.result_o, 0);
    chk({tag, "_rel_stall"}, bus.stall_o, 0);
  endtask

  initial begin
    logic rose;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.start_i      = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.annul_i      = 1'b0;
    repeat (2) tick();
    chk("reset_ready", bus.ready_o, 0);
    chk("reset_result", bus.result_o, 0);
    chk("reset_stall", bus.stall_o, 0);
    rst = 1'b0;
    tick();

    do_div("divu_fff9_2", 1'b0, 32'hFFFF_FFF9, 32'd2, {32'h0000_0001, 32'h7FFF_FFFC}, 33, 5);
    do_div("div_m7_2",    1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0);
    do_div("div_7_m2",    1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33, 0);
    do_div("div_5_0",     1'b1, 32'd5, 32'd0, 64'h0, 2, 1);
    do_div("div_ovf",     1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, 0);
    do_div("divu_big",    1'b0, 32'hFFFF_FFFF, 32'h8000_0001, {32'h7FFF_FFFE, 32'h1}, 33, 0);

    // Annul at cycle 10 of a run.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    rose = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (bus.ready_o !== 1'b0) rose = 1'b1;
    end
    bus.annul_i = 1'b1;
    #1;
    chk("annul10_stall_during", bus.stall_o, 0);
    tick();
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    #1;
    chk("annul10_stall_after", bus.stall_o, 0);
    chk("annul10_result", bus.result_o, 0);
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.ready_o !== 1'b0) rose = 1'b1;
    end
    chk("annul10_never_ready", rose, 0);

    // Annul while in FREE blocks acceptance.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b1;
    #1;
    chk("annul_free_stall", bus.stall_o, 0);
    tick();
    chk("annul_free_stall2", bus.stall_o, 0);
    chk("annul_free_ready", bus.ready_o, 0);
    bus.annul_i = 1'b0;
    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0);

    // Annul racing the final ON step.
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    repeat (32) tick();
    chk("annul32_not_ready_yet", bus.ready_o, 0);
    bus.annul_i = 1'b1;
    #1;
    chk("annul32_stall", bus.stall_o, 0);
    tick();
    chk("annul32_ready", bus.ready_o, 0);
    chk("annul32_result", bus.result_o, 0);
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    tick();

    // Reset at cycle 20 of a run.
    bus.signed_div_i = 1'b1;
    bus.opdata1_i    = 32'hFFFF_FFF9;
    bus.opdata2_i    = 32'd2;
    bus.start_i      = 1'b1;
    repeat (20) tick();
    rst = 1'b1;
    bus.start_i = 1'b0;
    tick();
    chk("rst20_ready", bus.ready_o, 0);
    chk("rst20_result", bus.result_o, 0);
    chk("rst20_stall", bus.stall_o, 0);
    rst = 1'b0;
    do_div("after_rst", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
